// File: rtl/score_ledger.sv
// score_ledger: live score counter, circular game history, sorted top-N table.
// Optional: define SCORE_SATURATE_EN to stop the score at 2^SCORE_W-1 instead of wrapping.
// Ports:
//   Clock, reset (async, active-low)
//   clear/commit pulses, run/pause levels from the game FSM
//   score, busy, new_record to display/menu
//   hist_addr -> hist_data (registered), hist_count
//   hs_sel -> hs_value (combinational)
module score_ledger #(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int TICKS_PER_SEC   = 10,
  parameter int SCORE_W         = 32,
  parameter int HIST_DEPTH      = 256,
  parameter int HS_ENTRIES      = 4
) (
  input  logic                          Clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          run,
  input  logic                          pause,
  input  logic                          commit,
  output logic [SCORE_W-1:0]            score,
  output logic                          busy,
  output logic                          new_record,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_addr,
  output logic [SCORE_W-1:0]            hist_data,
  output logic [$clog2(HIST_DEPTH):0]   hist_count,
  input  logic [$clog2(HS_ENTRIES):0]   hs_sel,
  output logic [SCORE_W-1:0]            hs_value
);

  localparam int DIV = CLOCK_FREQUENCY / TICKS_PER_SEC;
  localparam int PW  = $clog2(DIV);
  localparam int AW  = $clog2(HIST_DEPTH);
  localparam int SW  = $clog2(HS_ENTRIES) + 1;

  localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);
  localparam logic [AW:0]   FULL    = (AW + 1)'(HIST_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_PAUSE, S_COMMIT, S_RANK
  } state_t;

  state_t             state, state_nx;
  logic [PW-1:0]      presc;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      oldest;
  logic [AW-1:0]      rd_idx;
  logic               hist_hit;
  logic [SW-1:0]      rank_i;
  logic               ins_done;
  logic               last_rank;
  logic               take;
  logic               in_play;
  logic               restart;
  logic               advance;
  logic [SCORE_W-1:0] cur_hs;
  logic [SCORE_W-1:0] score_inc;
  logic [SCORE_W-1:0] hs  [HS_ENTRIES];
  logic [SCORE_W-1:0] mem [HIST_DEPTH];

  assign in_play   = (state == S_RUN) || (state == S_PAUSE);
  assign restart   = (in_play || state == S_IDLE) && !commit && clear;
  assign advance   = (state == S_RUN) && !commit && !clear
                   && !pause && run;
  assign last_rank = (rank_i == SW'(HS_ENTRIES - 1));
  assign take      = (state == S_RANK) && !ins_done
                   && (score > cur_hs);

`ifdef SCORE_SATURATE_EN
  assign score_inc = (score == '1) ? score : score + 1'b1;
`else
  assign score_inc = score + 1'b1;
`endif

  // Until the buffer has wrapped, entry 0 is the oldest.
  assign oldest   = (hist_count == FULL) ? wr_ptr : '0;
  assign rd_idx   = oldest + hist_addr;
  assign hist_hit = ({1'b0, hist_addr} < hist_count);

  always_comb begin
    cur_hs   = '0;
    hs_value = '0;
    for (int j = 0; j < HS_ENTRIES; j++) begin
      if (SW'(j) == rank_i) cur_hs = hs[j];
      if (SW'(j) == hs_sel) hs_value = hs[j];
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (commit)     state_nx = S_COMMIT;
        else if (clear) state_nx = S_RUN;
      end
      S_RUN: begin
        if (commit)     state_nx = S_COMMIT;
        else if (clear) state_nx = S_RUN;
        else if (pause) state_nx = S_PAUSE;
      end
      S_PAUSE: begin
        if (commit)               state_nx = S_COMMIT;
        else if (clear || !pause) state_nx = S_RUN;
      end
      S_COMMIT: state_nx = S_RANK;
      S_RANK:   if (last_rank) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_COMMIT) || (state == S_RANK);
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      score <= '0;
      presc <= PRE_TOP;
    end else begin
      unique case (1'b1)
        restart: begin
          score <= '0;
          presc <= PRE_TOP;
        end
        advance: begin
          if (presc == '0) begin
            presc <= PRE_TOP;
            score <= score_inc;
          end else begin
            presc <= presc - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (state == S_COMMIT) mem[wr_ptr] <= score;
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      hist_count <= '0;
      hist_data  <= '0;
      rank_i     <= '0;
      ins_done   <= 1'b0;
      new_record <= 1'b0;
      for (int j = 0; j < HS_ENTRIES; j++) hs[j] <= '0;
    end else begin
      hist_data <= hist_hit ? mem[rd_idx] : '0;
      if (restart) new_record <= 1'b0;
      if (state == S_COMMIT) begin
        wr_ptr     <= wr_ptr + 1'b1;
        if (hist_count != FULL) hist_count <= hist_count + 1'b1;
        rank_i     <= '0;
        ins_done   <= 1'b0;
        new_record <= 1'b0;
      end
      if (state == S_RANK) begin
        rank_i <= rank_i + 1'b1;
        if (take) begin
          ins_done <= 1'b1;
          if (rank_i == '0) new_record <= 1'b1;
        end
      end
      // Insertion: lower entries slide down, last one drops off.
      for (int j = 1; j < HS_ENTRIES; j++) begin
        if (take && SW'(j) > rank_i) hs[j] <= hs[j-1];
      end
      for (int j = 0; j < HS_ENTRIES; j++) begin
        if (take && SW'(j) == rank_i) hs[j] <= score;
      end
    end
  end

endmodule

// File: tb/tb_score_ledger.sv
// tb_score_ledger: randomized and directed checks of score_ledger
// against a queue/arithmetic reference model.
module tb_score_ledger;

  localparam int DIV = 10;
  localparam int N   = 4;
  localparam int D   = 4;

  logic        Clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        run = 1'b0;
  logic        pause = 1'b0;
  logic        commit = 1'b0;
  logic [31:0] score;
  logic        busy;
  logic        new_record;
  logic [1:0]  hist_addr = '0;
  logic [31:0] hist_data;
  logic [2:0]  hist_count;
  logic [2:0]  hs_sel = '0;
  logic [31:0] hs_value;

  logic       o_clear = 1'b0;
  logic       o_run = 1'b0;
  logic       o_pause = 1'b0;
  logic       o_commit = 1'b0;
  logic [3:0] o_score;
  logic       o_busy;
  logic       o_nr;
  logic [0:0] o_hist_addr = '0;
  logic [3:0] o_hist_data;
  logic [1:0] o_hist_count;
  logic [0:0] o_hs_sel = '0;
  logic [3:0] o_hs_value;

  int n_vec = 0;
  int n_err = 0;

  int m_busy;
  int m_act;
  bit m_game;
  bit m_paused;
  bit m_nr;
  int tbl[N];
  int hq[$];

  score_ledger #(
    .CLOCK_FREQUENCY(100), .TICKS_PER_SEC(10), .SCORE_W(32),
    .HIST_DEPTH(D), .HS_ENTRIES(N)
  ) dut (
    .Clock(Clock), .reset(reset), .clear(clear), .run(run),
    .pause(pause), .commit(commit), .score(score), .busy(busy),
    .new_record(new_record), .hist_addr(hist_addr),
    .hist_data(hist_data), .hist_count(hist_count),
    .hs_sel(hs_sel), .hs_value(hs_value)
  );

  score_ledger #(
    .CLOCK_FREQUENCY(20), .TICKS_PER_SEC(10), .SCORE_W(4),
    .HIST_DEPTH(2), .HS_ENTRIES(1)
  ) dut_ovf (
    .Clock(Clock), .reset(reset), .clear(o_clear), .run(o_run),
    .pause(o_pause), .commit(o_commit), .score(o_score),
    .busy(o_busy), .new_record(o_nr), .hist_addr(o_hist_addr),
    .hist_data(o_hist_data), .hist_count(o_hist_count),
    .hs_sel(o_hs_sel), .hs_value(o_hs_value)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_score();
    return m_act / DIV;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_act = 0; m_game = 0; m_paused = 0; m_nr = 0;
    for (int i = 0; i < N; i++) tbl[i] = 0;
    hq.delete();
  endtask

  task automatic m_commit();
    int s;
    s = m_score();
    hq.push_back(s);
    if (hq.size() > D) void'(hq.pop_front());
    m_nr = (s > tbl[0]);
    for (int i = 0; i < N; i++) begin
      if (s > tbl[i]) begin
        for (int j = N - 1; j > i; j--) tbl[j] = tbl[j-1];
        tbl[i] = s;
        break;
      end
    end
    m_busy = N + 1;
    m_game = 0;
  endtask

  task automatic m_update();
    if (m_busy > 0) m_busy--;
    else if (!m_game) begin
      if (commit) m_commit();
      else if (clear) begin
        m_game = 1; m_paused = 0; m_act = 0; m_nr = 0;
      end
    end else begin
      if (commit) m_commit();
      else if (clear) begin
        m_act = 0; m_paused = 0; m_nr = 0;
      end else if (m_paused) begin
        if (!pause) m_paused = 0;
      end else if (pause) m_paused = 1;
      else if (run) m_act++;
    end
  endtask

  task automatic step();
    @(posedge Clock);
    m_update();
    @(negedge Clock);
    chk("score", score, m_score());
    chk("busy", busy, m_busy > 0);
    if (m_busy == 0) begin
      chk("new_record", new_record, m_nr);
      chk("hist_count", hist_count, hq.size());
    end
  endtask

  task automatic game_score(input int s);
    clear = 1; step(); clear = 0;
    run = 1;
    for (int k = 0; k < 2000 && m_score() != s; k++) step();
    run = 0;
    chk("run_to", score, s);
  endtask

  task automatic commit_score(input int s, input int exp_nr);
    int bc;
    game_score(s);
    commit = 1; step(); commit = 0;
    bc = busy ? 1 : 0;
    for (int k = 0; k < 20 && busy; k++) begin
      step();
      if (busy) bc++;
    end
    chk("busy_len", bc, N + 1);
    if (exp_nr >= 0) chk("nr_const", new_record, exp_nr);
  endtask

  task automatic check_table();
    for (int i = 0; i < 6; i++) begin
      hs_sel = 3'(i);
      #1;
      chk("hs_value", hs_value, (i < N) ? tbl[i] : 0);
    end
    hs_sel = 3'd7; #1;
    chk("hs_oob", hs_value, 0);
    hs_sel = '0;
    @(negedge Clock);
  endtask

  task automatic check_hist();
    for (int a = 0; a < D; a++) begin
      hist_addr = 2'(a);
      step();
      chk("hist_data", hist_data, (a < hq.size()) ? hq[a] : 0);
    end
    hist_addr = '0;
  endtask

  initial begin
    int first;
    int cnt;
    int exp_tbl[N];
    exp_tbl = '{70, 60, 50, 30};
    m_reset();

    #1 reset = 0;
    repeat (3) @(negedge Clock);
    chk("rst_score", score, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nr", new_record, 0);
    chk("rst_hcount", hist_count, 0);
    chk("rst_hdata", hist_data, 0);
    chk("rst_oscore", o_score, 0);
    check_table();
    reset = 1;
    step();

    clear = 1; step(); clear = 0;
    run = 1;
    first = -1;
    for (int k = 1; k <= 55; k++) begin
      step();
      if (first < 0 && score == 1) first = k;
    end
    chk("first_inc", first, DIV);
    chk("tick_score", score, 5);

    pause = 1;
    repeat (37) step();
    chk("pause_hold", score, 5);
    pause = 0;
    cnt = 0;
    for (int k = 0; k < 30 && score != 6; k++) begin
      step();
      cnt++;
    end
    chk("resume_cnt", cnt, 6);

    for (int k = 0; k < 300; k++) begin
      run   = ($urandom_range(0, 3) != 0);
      pause = ($urandom_range(0, 4) == 0);
      clear = ($urandom_range(0, 99) == 0);
      step();
    end
    run = 0; pause = 0; clear = 0;
    step();

    commit_score(50, 1);
    commit_score(30, 0);
    commit_score(70, 1);
    commit_score(30, 0);
    commit_score(60, 0);
    for (int i = 0; i < N; i++) begin
      hs_sel = 3'(i); #1;
      chk("tbl_const", hs_value, exp_tbl[i]);
    end
    check_table();

    for (int s = 1; s <= 6; s++) commit_score(s, -1);
    chk("hwrap_cnt", hist_count, 4);
    for (int a = 0; a < D; a++) begin
      hist_addr = 2'(a);
      step();
      chk("hwrap_const", hist_data, a + 3);
    end
    check_hist();

    for (int k = 0; k < 3; k++) begin
      commit_score($urandom_range(0, 90), -1);
      check_table();
    end

    game_score(99);
    commit = 1; step(); commit = 0;
    step(); step();
    reset = 0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_score", score, 0);
    chk("mid_hcount", hist_count, 0);
    chk("mid_nr", new_record, 0);
    m_reset();
    check_table();
    reset = 1;
    commit_score(7, 1);
    check_table();
    check_hist();

    o_clear = 1; step(); o_clear = 0;
    o_run = 1;
    repeat (30) step();
    chk("ovf_15", o_score, 15);
    repeat (2) step();
`ifdef SCORE_SATURATE_EN
    chk("ovf_a", o_score, 15);
`else
    chk("ovf_a", o_score, 0);
`endif
    repeat (2) step();
`ifdef SCORE_SATURATE_EN
    chk("ovf_b", o_score, 15);
`else
    chk("ovf_b", o_score, 1);
`endif
    o_run = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
